div_iter: RTL and testbench

Iterative 32-bit radix-2 divider for the EX stage's DIV/DIVU instructions. It is the responder side of the EX-stage divider handshake (start/flag_unsigned/operand1/operand2 in, result/done out). The EX stage holds `start` high and stalls until `done` arrives. It then reads `result` as {HI, LO} = {remainder, quotient} while the instruction drains.

---
 rtl/div_iter.sv | 137 +++++++++++++
 tb/tb_div_iter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the EX-stage DIV/DIVU handshake.
// One quotient bit is produced per cycle; the answer is {remainder, quotient}.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   start          level request, held by EX while a DIV/DIVU occupies EX
//   flag_unsigned  1 = DIVU, 0 = DIV; sampled with the operands at the accepting edge
//   operand1       dividend (rs)
//   operand2       divisor (rt)
//   result         {remainder, quotient}, registered, held until the next FIX
//   done           single-cycle registered completion pulse
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               flag_unsigned,
   input  logic [WIDTH-1:0]   operand1,
   input  logic [WIDTH-1:0]   operand2,
   output logic [2*WIDTH-1:0] result,
   output logic               done
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [2:0] {StIdle, StBusy, StFix, StDone, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  rem_q, rem_d;   // partial remainder
   logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend, becomes the quotient as it shifts out
   logic [WIDTH-1:0]  dsr_q, dsr_d;   // divisor magnitude
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] result_d;
   logic              done_d;

   logic              sign1, sign2, div_zero;
   logic [WIDTH-1:0]  mag1, mag2;
   logic [WIDTH:0]    shifted, diff;

   // A zero divisor latches the raw dividend with no sign flags: the restoring loop then
   // yields quotient all-ones and remainder equal to the original operand1, uncorrected.
   assign div_zero = (operand2 == '0);
   assign sign1    = operand1[WIDTH-1] & ~flag_unsigned;
   assign sign2    = operand2[WIDTH-1] & ~flag_unsigned;
   assign mag1     = (sign1 && !div_zero) ? -operand1 : operand1;
   assign mag2     = sign2 ? -operand2 : operand2;

   // 0x80000000 negates to itself and is then treated as an unsigned magnitude.
   assign shifted  = {rem_q, dvd_q[WIDTH-1]};
   assign diff     = shifted - {1'b0, dsr_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result;
      done_d    = 1'b0;

      case (state_q)
         // HOLD has already swallowed the cycle where EX still showed the finished
         // instruction (that edge was seen in DONE), so its exit edge may accept anew.
         StIdle, StHold: begin
            state_d = StIdle;
            if (start) begin
               state_d   = StBusy;
               cnt_d     = '0;
               rem_d     = '0;
               dvd_d     = mag1;
               dsr_d     = mag2;
               neg_quo_d = (sign1 ^ sign2) & ~div_zero;
               neg_rem_d = sign1 & ~div_zero;
            end
         end
         StBusy: begin
            if (!start) begin
               state_d = StIdle;
            end else begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            result_d = {(neg_rem_q ? -rem_q : rem_q), (neg_quo_q ? -dvd_q : dvd_q)};
            done_d   = 1'b1;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StHold;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result    <= result_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed bench for div_iter. A timing/arithmetic model predicts, for every
// cycle, the done pulse and the held result; a compare process checks the DUT on each
// falling edge. Hand-computed literals pin the arithmetic model.
module tb_div_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flag_unsigned = 1'b0;
   logic [31:0] operand1 = '0;
   logic [31:0] operand2 = '0;
   logic [63:0] result;
   logic        done;

   div_iter #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .flag_unsigned (flag_unsigned),
      .operand1      (operand1),
      .operand2      (operand2),
      .result        (result),
      .done          (done)
   );

   always #5 clock = ~clock;

   int edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   bit          pending = 1'b0;
   bit          exp_done = 1'b0;
   int          done_edge = 0;
   logic [63:0] pend_val = '0;
   logic [63:0] model_res = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
      end
   endtask

   // {remainder, quotient} straight from the arithmetic rules.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input bit uns);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (uns) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Result becomes visible 33 edges after the accepting edge, done for that one cycle.
   always @(negedge clock) begin
      if (chk_en) begin
         exp_done = pending && (edge_cnt == done_edge);
         if (exp_done) begin
            model_res = pend_val;
            pending   = 1'b0;
         end
         check("done", {63'd0, done}, {63'd0, exp_done});
         check("result", result, model_res);
      end
   end

   // Called just after a rising edge; the next edge is the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit uns,
                        input logic [63:0] lit);
      operand1      = a;
      operand2      = b;
      flag_unsigned = uns;
      start         = 1'b1;
      pend_val      = model(a, b, uns);
      check("model", pend_val, lit);
      done_edge     = edge_cnt + 1 + 33;
      pending       = 1'b1;
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input bit uns,
                      input logic [63:0] lit);
      @(posedge clock); #1;
      issue(a, b, uns, lit);
      repeat (35) @(posedge clock);  // through T34
      #1 start = 1'b0;
   endtask

   // Start 100/7, then pull reset low just after edge Tn.
   task automatic reset_at(input int n);
      @(posedge clock); #1;
      issue(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
      repeat (n + 1) @(posedge clock);
      #1;
      reset     = 1'b0;
      start     = 1'b0;
      pending   = 1'b0;
      model_res = '0;
      #1;
      check("rst_result", result, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   initial begin
      #1 reset = 1'b0;
      #11;
      check("reset_result", result, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      @(posedge clock); #1;
      reset  = 1'b1;
      chk_en = 1'b1;

      run(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
      run(32'hFFFF_FFF9, 32'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
      run(32'd7, 32'hFFFF_FFFE, 1'b0, 64'h00000001_FFFFFFFD);
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h00000000_80000000);
      run(32'hFFFF_FFFF, 32'd1, 1'b1, 64'h00000000_FFFFFFFF);
      run(32'h1234_5678, 32'd0, 1'b1, 64'h12345678_FFFFFFFF);
      run(32'h1234_5678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF);
      run(32'hFFFF_FFF9, 32'd0, 1'b0, 64'hFFFFFFF9_FFFFFFFF);
      run(32'd1000, 32'd1000, 1'b0, 64'h00000000_00000001);

      // Back-to-back with start held: second accept at T35, done at T68.
      @(posedge clock); #1;
      issue(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
      repeat (35) @(posedge clock);
      #1;
      issue(32'd9, 32'd3, 1'b1, 64'h00000000_00000003);
      repeat (35) @(posedge clock);
      #1 start = 1'b0;

      // Abort: start sampled low at T10; result must keep 9/3's value.
      @(posedge clock); #1;
      issue(32'd200, 32'd9, 1'b1, 64'h00000002_00000016);
      repeat (10) @(posedge clock);
      #1;
      start   = 1'b0;
      pending = 1'b0;
      repeat (40) @(posedge clock);

      reset_at(20);
      run(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
      reset_at(33);  // done is high when reset hits
      run(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);

      repeat (3) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
